// File: rtl/user_rng_prefetch.sv
// user_rng_prefetch: OBI read manager that prefetches random words from the
// xorshift subordinate into a small first-word-fall-through FIFO and hands
// them to downstream logic as a valid/ready stream. At most one read is in
// flight; a flush (clear_i) discards any response that is still outstanding.
module user_rng_prefetch #(
    parameter int unsigned                ADDR_WIDTH_OBI = 32,
    parameter int unsigned                DATA_WIDTH_OBI = 32,
    parameter int unsigned                ID_WIDTH_OBI   = 1,
    parameter logic [ADDR_WIDTH_OBI-1:0]  BASE_ADDR      = 32'h2000_0000,
    parameter int unsigned                FIFO_DEPTH     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic                          clear_i,
    output logic                          req_o,
    output logic                          we_o,
    output logic [3:0]                    be_o,
    output logic [ADDR_WIDTH_OBI-1:0]     addr_o,
    output logic [DATA_WIDTH_OBI-1:0]     wdata_o,
    output logic [ID_WIDTH_OBI-1:0]       aid_o,
    input  logic                          gnt_i,
    input  logic                          rvalid_i,
    input  logic [DATA_WIDTH_OBI-1:0]     rdata_i,
    input  logic [ID_WIDTH_OBI-1:0]       rid_i,
    input  logic                          err_i,
    output logic                          rnd_valid_o,
    output logic [DATA_WIDTH_OBI-1:0]     rnd_data_o,
    input  logic                          rnd_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          err_o,
    output logic [7:0]                    err_cnt_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam logic [FILL_W-1:0] DEPTH_FILL = FILL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t                     state_q, state_d;
    logic [9:0]                 word_idx_q;
    logic [9:0]                 req_idx_q;
    logic                       drop_q;
    logic [DATA_WIDTH_OBI-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]           wptr_q, rptr_q;
    logic [FILL_W-1:0]          fill_q;
    logic                       err_q;
    logic [7:0]                 err_cnt_q;

    logic [9:0] addr_idx;
    logic       resp_bad, resp_take, discard, push, pop, err_evt, grant;

    // A response is only meaningful while waiting for one; anything else is a protocol error.
    assign resp_bad  = err_i || (rid_i != '0);
    assign resp_take = (state_q == ST_WAIT) && rvalid_i;
    assign discard   = drop_q || clear_i;
    assign push      = resp_take && !resp_bad && !discard;
    assign pop       = (fill_q != '0) && rnd_ready_i && !clear_i;
    assign err_evt   = (resp_take && resp_bad && !discard) || (rvalid_i && (state_q != ST_WAIT));
    assign grant     = (state_q == ST_REQ) && gnt_i;

    // While a request is pending the address comes from the index captured at
    // issue, so a flush cannot move addr_o before the grant.
    assign addr_idx = (state_q == ST_REQ) ? req_idx_q : word_idx_q;
    assign addr_o   = BASE_ADDR + ADDR_WIDTH_OBI'({addr_idx, 2'b00});

    assign we_o        = 1'b0;
    assign be_o        = 4'hF;
    assign wdata_o     = '0;
    assign aid_o       = '0;
    assign rnd_valid_o = (fill_q != '0);
    assign rnd_data_o  = mem_q[rptr_q];
    assign fill_o      = fill_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;

    // Next-state and request decode: one read in flight, request held until granted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        req_o   = 1'b0;
        case (state_q)
            ST_IDLE: if (enable_i && !clear_i && (fill_q < DEPTH_FILL)) state_d = ST_REQ;
            ST_REQ: begin
                req_o = 1'b1;
                if (gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: if (rvalid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus address bookkeeping and the drop flag for flushed responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            req_idx_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear_i) begin
                word_idx_q <= '0;
            end else if (grant && !drop_q) begin
                word_idx_q <= word_idx_q + 10'd1;
            end
            if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
                req_idx_q <= word_idx_q;
            end
            if (resp_take) begin
                drop_q <= 1'b0;
            end else if (clear_i && (state_q != ST_IDLE)) begin
                drop_q <= 1'b1;
            end
        end
    end

    // FIFO storage and pointers; a flush wins over a same-cycle push or pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the storage is reset too so rnd_data_o reads 0 out of reset; it is only a few words.
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= rdata_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Sticky error flag and saturating error counter; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (err_evt) begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_user_rng_prefetch.sv
// tb_user_rng_prefetch: drives user_rng_prefetch against a configurable OBI
// responder and checks it with a stimulus table, directed corner sequences and
// a queue-based reference model of the stream, address sequence and errors.
module tb_user_rng_prefetch;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] DBASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i, clear_i, rnd_ready_i;
    logic        req_o, we_o, gnt_i, rvalid_i, err_i, rnd_valid_o, err_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o, wdata_o, rdata_i, rnd_data_o;
    logic [0:0]  aid_o, rid_i;
    logic [2:0]  fill_o;
    logic [7:0]  err_cnt_o;

    int errors = 0;
    int checks = 0;

    // responder configuration (written by the test) and state
    int   gnt_delay = 0, resp_delay = 0, err_on_read = -1;
    logic err_rand = 1'b0, err_all = 1'b0;
    int   nreads, gcnt, pend_cnt;
    logic pend, pend_err, pend_rid;
    logic [31:0] pend_data;

    // reference model state
    logic [31:0] mq[$];
    logic [31:0] addr_log[$];
    int   exp_idx, err_exp;
    logic outstanding, drop_m;

    always #5 clk = ~clk;

    user_rng_prefetch dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable_i), .clear_i(clear_i),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .aid_o(aid_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .rid_i(rid_i), .err_i(err_i), .rnd_valid_o(rnd_valid_o), .rnd_data_o(rnd_data_o),
        .rnd_ready_i(rnd_ready_i), .fill_o(fill_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // OBI subordinate: grant after gnt_delay cycles of request, answer resp_delay cycles after grant.
    assign gnt_i    = req_o && (gcnt >= gnt_delay);
    assign rvalid_i = pend && (pend_cnt == 0);
    assign rdata_i  = rvalid_i ? pend_data : '0;
    assign err_i    = rvalid_i && pend_err;
    assign rid_i    = rvalid_i & pend_rid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nreads <= 0; gcnt <= 0; pend <= 1'b0; pend_cnt <= 0;
            pend_data <= '0; pend_err <= 1'b0; pend_rid <= 1'b0;
        end else if (req_o && gnt_i) begin
            gcnt      <= 0;
            pend      <= 1'b1;
            pend_cnt  <= resp_delay;
            pend_data <= DBASE + {22'd0, addr_o[11:2]};
            pend_err  <= err_all || (nreads == err_on_read) || (err_rand && ($urandom_range(5) == 0));
            pend_rid  <= err_rand && ($urandom_range(9) == 0);
            nreads    <= nreads + 1;
        end else begin
            if (req_o) gcnt <= gcnt + 1;
            if (pend) begin
                if (pend_cnt == 0) pend <= 1'b0;
                else pend_cnt <= pend_cnt - 1;
            end
        end
    end

    // Reference model: checks visible state, then applies the bus events of the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete(); addr_log.delete();
            exp_idx = 0; err_exp = 0; outstanding = 1'b0; drop_m = 1'b0;
        end else begin
            logic do_pop, do_push;
            logic [31:0] pdata;
            check("m_fill", 32'(fill_o), mq.size());
            check("m_valid", 32'(rnd_valid_o), 32'(mq.size() != 0));
            if (mq.size() != 0) check("m_head", rnd_data_o, mq[0]);
            check("m_err_o", 32'(err_o), 32'(err_exp != 0));
            check("m_err_cnt", 32'(err_cnt_o), (err_exp > 255) ? 255 : err_exp);
            do_pop  = (mq.size() != 0) && rnd_ready_i;
            do_push = 1'b0;
            pdata   = rdata_i;
            if (rvalid_i) begin
                if (outstanding) begin
                    outstanding = 1'b0;
                    if (!drop_m && !clear_i) begin
                        if (err_i || (rid_i != 0)) err_exp++;
                        else do_push = 1'b1;
                    end
                    drop_m = 1'b0;
                end else begin
                    err_exp++;
                end
            end
            if (clear_i) mq.delete();
            else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(pdata);
            end
            if (req_o && gnt_i) begin
                addr_log.push_back(addr_o);
                if (!drop_m) begin
                    check("m_addr", addr_o, BASE + 32'(exp_idx * 4));
                    if (!clear_i) exp_idx = (exp_idx + 1) % 1024;
                end
                outstanding = 1'b1;
            end
            if (clear_i) begin
                exp_idx = 0;
                if (req_o || outstanding) drop_m = 1'b1;
            end
        end
    end

    task automatic do_reset();
        enable_i = 1'b0; clear_i = 1'b0; rnd_ready_i = 1'b0;
        gnt_delay = 0; resp_delay = 0; err_on_read = -1; err_rand = 1'b0; err_all = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check("rst_req", 32'(req_o), 0);
        check("rst_we", 32'(we_o), 0);
        check("rst_be", 32'(be_o), 32'hF);
        check("rst_addr", addr_o, BASE);
        check("rst_wdata", wdata_o, 0);
        check("rst_aid", 32'(aid_o), 0);
        check("rst_valid", 32'(rnd_valid_o), 0);
        check("rst_data", rnd_data_o, 0);
        check("rst_fill", 32'(fill_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_errcnt", 32'(err_cnt_o), 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        enable;
        logic        ready;
        int          cycles;
        int          exp_fill;
        logic        exp_valid;
        logic [31:0] exp_head;
        logic        exp_req;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n0, i;
        logic [31:0] a0;
        logic [31:0] exp_words[4];

        vecs[0] = '{1'b1, 1'b0, 20, 4, 1'b1, 32'h1000_0000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1,  3, 1'b1, 32'h1000_0001, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 2,  1, 1'b1, 32'h1000_0003, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 3,  0, 1'b0, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 1'b0, 20, 4, 1'b1, 32'h1000_0004, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 4,  0, 1'b0, 32'h0,         1'b0};

        do_reset();

        // fill, saturate, drain in table steps
        for (int v = 0; v < 6; v++) begin
            enable_i = vecs[v].enable;
            rnd_ready_i = vecs[v].ready;
            repeat (vecs[v].cycles) step();
            check($sformatf("vec%0d_fill", v), 32'(fill_o), vecs[v].exp_fill);
            check($sformatf("vec%0d_valid", v), 32'(rnd_valid_o), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) check($sformatf("vec%0d_head", v), rnd_data_o, vecs[v].exp_head);
            check($sformatf("vec%0d_req", v), 32'(req_o), 32'(vecs[v].exp_req));
        end
        check("addr_seq0", addr_log[0], 32'h2000_0000);
        check("addr_seq3", addr_log[3], 32'h2000_000C);

        // steady-state throughput: one grant every 3 cycles
        enable_i = 1'b1; rnd_ready_i = 1'b1;
        n0 = nreads;
        repeat (30) step();
        check("throughput", nreads - n0, 10);

        // delayed grant with enable dropped while the request is pending
        do_reset();
        gnt_delay = 5;
        enable_i = 1'b1;
        i = 0;
        while (!req_o && i < 10) begin step(); i++; end
        check("gd_req_start", 32'(req_o), 1);
        a0 = addr_o;
        check("gd_addr", a0, BASE);
        n0 = nreads;
        i = 0;
        while (nreads == n0 && i < 20) begin
            check("gd_req_held", 32'(req_o), 1);
            check("gd_addr_held", addr_o, a0);
            if (i == 1) enable_i = 1'b0;
            step();
            i++;
        end
        check("gd_granted", nreads, n0 + 1);
        repeat (10) step();
        check("gd_no_new_req", nreads, n0 + 1);
        check("gd_fill", 32'(fill_o), 1);
        check("gd_head", rnd_data_o, DBASE);

        // error on the third read
        do_reset();
        err_on_read = 2;
        enable_i = 1'b1;
        repeat (30) step();
        check("er_fill", 32'(fill_o), 4);
        check("er_err_o", 32'(err_o), 1);
        check("er_err_cnt", 32'(err_cnt_o), 1);
        check("er_next_addr", addr_log[3], 32'h2000_000C);
        exp_words[0] = 32'h1000_0000; exp_words[1] = 32'h1000_0001;
        exp_words[2] = 32'h1000_0003; exp_words[3] = 32'h1000_0004;
        enable_i = 1'b0; rnd_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("er_word%0d", k), rnd_data_o, exp_words[k]);
            step();
        end
        check("er_drained", 32'(fill_o), 0);

        // address wrap after 1024 reads
        do_reset();
        enable_i = 1'b1; rnd_ready_i = 1'b1;
        i = 0;
        while (nreads < 1025 && i < 4000) begin step(); i++; end
        check("wrap_count", nreads, 1025);
        if (addr_log.size() >= 1025) begin
            check("wrap_last", addr_log[1023], 32'h2000_0FFC);
            check("wrap_first", addr_log[1024], 32'h2000_0000);
        end else begin
            check("wrap_log", addr_log.size(), 1025);
        end

        // flush while waiting for a (faulty) response with two words buffered
        do_reset();
        resp_delay = 3;
        err_on_read = 2;
        enable_i = 1'b1;
        i = 0;
        while (nreads < 3 && i < 100) begin step(); i++; end
        check("cl_reads", nreads, 3);
        check("cl_fill_before", 32'(fill_o), 2);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("cl_fill_after", 32'(fill_o), 0);
        i = 0;
        while (nreads < 4 && i < 50) begin step(); i++; end
        check("cl_reads_after", nreads, 4);
        if (addr_log.size() >= 4) check("cl_next_addr", addr_log[3], 32'h2000_0000);
        repeat (6) step();
        check("cl_err_cnt", 32'(err_cnt_o), 0);
        check("cl_head", rnd_data_o, 32'h1000_0000);

        // error counter saturation
        do_reset();
        err_all = 1'b1;
        enable_i = 1'b1;
        i = 0;
        while (nreads < 300 && i < 1500) begin step(); i++; end
        repeat (5) step();
        check("sat_err_cnt", 32'(err_cnt_o), 255);
        check("sat_err_o", 32'(err_o), 1);
        check("sat_fill", 32'(fill_o), 0);

        // randomized traffic against the model, ending in a reset mid-transaction
        do_reset();
        err_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                gnt_delay  = $urandom_range(2);
                resp_delay = $urandom_range(2);
            end
            enable_i    = ($urandom_range(7) != 0);
            rnd_ready_i = ($urandom_range(3) != 0);
            clear_i     = ($urandom_range(39) == 0);
            step();
        end
        clear_i = 1'b0;
        enable_i = 1'b1;
        i = 0;
        while (!req_o && i < 20) begin step(); i++; end
        do_reset();
        repeat (3) step();
        check("post_reset_fill", 32'(fill_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/user_rng_prefetch.md
Name: user_rng_prefetch

Overview:
- OBI manager that streams random words from the user-domain xorshift subordinate.
- Issues OBI reads to consecutive word addresses in the subordinate's 4 KiB window.
- Buffers returned words in a small first-word-fall-through FIFO.
- Presents the words as a valid/ready stream to downstream user logic (answer selector), hiding OBI latency.

Parameters:
- ADDR_WIDTH_OBI, 32, OBI address width.
- DATA_WIDTH_OBI, 32, OBI data width and stream data width.
- ID_WIDTH_OBI, 1, OBI transaction ID width.
- BASE_ADDR, 32'h2000_0000, base address of the xorshift subordinate window.
- FIFO_DEPTH, 4, number of buffered words; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  allows issuing new requests
- clear_i  in  1  synchronous flush of FIFO and address index
- req_o  out  1  OBI request
- we_o  out  1  OBI write enable; constant 0
- be_o  out  4  OBI byte enable; constant 4'hF
- addr_o  out  ADDR_WIDTH_OBI  OBI address
- wdata_o  out  DATA_WIDTH_OBI  constant 0
- aid_o  out  ID_WIDTH_OBI  constant 0
- gnt_i  in  1  OBI grant
- rvalid_i  in  1  OBI response valid
- rdata_i  in  DATA_WIDTH_OBI  OBI read data
- rid_i  in  ID_WIDTH_OBI  OBI response ID
- err_i  in  1  OBI response error
- rnd_valid_o  out  1  stream word available
- rnd_data_o  out  DATA_WIDTH_OBI  FIFO head word
- rnd_ready_i  in  1  downstream accepts word
- fill_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- err_o  out  1  sticky error flag
- err_cnt_o  out  8  saturating error count

Behaviour:

Reset:
- All outputs 0 except be_o = 4'hF.
- addr_o = BASE_ADDR.
- FSM in IDLE; word_idx = 0; FIFO empty; drop flag = 0.

Addressing:
- addr_o = BASE_ADDR + {word_idx[9:0], 2'b00}.
- word_idx is 10 bits; increments on each accepted request (req_o && gnt_i).
- Wraps 1023 -> 0.

FSM (at most one outstanding transaction):
- IDLE:
  - Go to REQ when enable_i && !clear_i && (fill + 0) < FIFO_DEPTH.
  - req_o is asserted combinationally from the REQ state only, i.e. one cycle after the decision.
- REQ:
  - req_o = 1; addr_o held stable until gnt_i.
  - On gnt_i: word_idx++ and go to WAIT.
  - enable_i falling in REQ does not withdraw req_o; OBI rule: a request is held until granted.
- WAIT:
  - req_o = 0; wait for rvalid_i.
  - Response arriving in the same cycle as the grant is not possible: the subordinate responds at the earliest one cycle after grant.
  - On rvalid_i:
    - If err_i = 1, rid_i != 0, or the drop flag is set: discard the data.
    - Otherwise push rdata_i into the FIFO.
    - Next state is IDLE.
- Throughput: one word per 3 cycles with a zero-wait subordinate (IDLE, REQ, WAIT).

Errors:
- Error = rvalid_i && (err_i || rid_i != 0) while in WAIT.
- Not counted when drop is set.
- Each error sets err_o (sticky until reset) and increments err_cnt_o, saturating at 255.
- clear_i does not clear error state.
- rvalid_i outside WAIT is ignored and counted as an error.

FIFO:
- First-word-fall-through: rnd_valid_o = (fill != 0); rnd_data_o = head word.
- Pop when rnd_valid_o && rnd_ready_i.
- Push and pop in the same cycle: fill unchanged, data ordering preserved.
- Overflow is impossible because a request is only started when fill < FIFO_DEPTH with nothing outstanding.
- rnd_ready_i with empty FIFO: no effect.

clear_i (synchronous, one cycle):
- Empties the FIFO and sets word_idx = 0.
- In IDLE: stays IDLE.
- In REQ: request completes normally (held until grant). word_idx is set to 0 and the grant increment is suppressed. The drop flag is set so the response is discarded.
- In WAIT: drop flag is set; the pending response is discarded.
- Drop flag is cleared when the discarded response arrives.
- clear_i has priority over a same-cycle push or pop.

Asynchronous reset mid-transaction returns everything to reset values. The bench responder must also be reset.

Test Plan:
- Reset, enable_i = 1, zero-wait responder returning 32'h1000_0000 + (addr[11:2]), rnd_ready_i = 0 -> reads issued at 0x2000_0000, 0x2000_0004, 0x2000_0008, 0x2000_000C; fill_o saturates at 4; no further req_o; stream head = 32'h1000_0000.
- Continue with rnd_ready_i = 1 -> stream delivers 32'h1000_0000, 0x..01, 0x..02, ... in order with no gaps or duplicates; steady-state one word per 3 cycles.
- Responder delays gnt_i 5 cycles with enable_i dropped in cycle 2 -> req_o and addr_o stay stable until grant; response is pushed; no new request afterwards.
- Responder returns err_i = 1 on the third read -> word 2 is absent from the stream; err_o = 1; err_cnt_o = 1; address index still advances (next address 0x2000_000C).
- Run 1025 reads -> address wraps from 0x2000_0FFC to 0x2000_0000.
- Assert clear_i while in WAIT, with FIFO holding 2 words -> fill_o = 0 the next cycle; the pending response is discarded; err_cnt_o is unchanged; the next request is issued to 0x2000_0000.
